// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : Instruction prefetch queue between a variable-latency instruction
//            memory and decode. Credit-limited sequential fetch, in-order
//            response buffering with PCs, and flush/restart on redirect with
//            in-flight response discard. Optional same-cycle bypass of an
//            empty queue is enabled by defining FETCH_QUEUE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);

    localparam int            c_PW        = $clog2(DEPTH);
    localparam int            c_CW        = c_PW + 1;
    localparam logic [c_CW:0] c_DEPTH_EXT = (c_CW + 1)'(DEPTH);

    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_rsp_pc;
    logic [c_CW-1:0] r_count;
    logic [c_CW-1:0] r_outstanding;
    logic [c_CW-1:0] r_drop_cnt;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_PW-1:0] r_wr_ptr;
    logic [31:0]     r_buf_pc   [DEPTH];
    logic [31:0]     r_buf_data [DEPTH];

    logic            w_credit_ok;
    logic            w_req_fire;
    logic            w_rsp_keep;
    logic            w_queue_ne;
    logic            w_bypass;
    logic            w_push;
    logic            w_pop;
    logic [31:0]     w_redirect_pc;
    logic            w_unused_ok;

    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
    assign w_unused_ok   = &{1'b0, redirect_pc[1:0]};

    // Queued plus in-flight never exceeds DEPTH, so every response has a slot.
    assign w_credit_ok   = ({1'b0, r_count} + {1'b0, r_outstanding}) < c_DEPTH_EXT;
    assign mem_req_valid = !rst && !redirect && w_credit_ok;
    assign mem_req_addr  = r_fetch_pc;
    assign w_req_fire    = mem_req_valid && mem_req_ready;

    assign w_rsp_keep    = mem_rsp_valid && (r_drop_cnt == '0) && !redirect && !rst;
    assign w_queue_ne    = (r_count != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign w_bypass      = !w_queue_ne && w_rsp_keep;
`else
    assign w_bypass      = 1'b0;
`endif

    assign inst_valid    = !rst && !redirect && (w_queue_ne || w_bypass);
    assign inst_data     = w_bypass ? mem_rsp_data : r_buf_data[r_rd_ptr];
    assign inst_pc       = w_bypass ? r_rsp_pc     : r_buf_pc[r_rd_ptr];

    // A bypassed instruction taken by decode is never written to the queue.
    assign w_pop         = inst_valid && inst_ready && w_queue_ne;
    assign w_push        = w_rsp_keep && !(w_bypass && inst_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else if (redirect) begin
            // A response arriving now is already discarded, hence the minus one.
            r_fetch_pc    <= w_redirect_pc;
            r_rsp_pc      <= w_redirect_pc;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_outstanding <= r_outstanding - c_CW'(mem_rsp_valid);
            r_drop_cnt    <= r_outstanding - c_CW'(mem_rsp_valid);
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            r_outstanding <= r_outstanding + c_CW'(w_req_fire) - c_CW'(mem_rsp_valid);
            if (mem_rsp_valid) begin
                if (r_drop_cnt != '0) begin
                    r_drop_cnt <= r_drop_cnt - c_CW'(1);
                end else begin
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                end
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
            r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_buf_pc[i]   <= 32'd0;
                r_buf_data[i] <= 32'd0;
            end
        end else if (w_push) begin
            r_buf_pc[r_wr_ptr]   <= r_rsp_pc;
            r_buf_data[r_wr_ptr] <= mem_rsp_data;
        end
    end

endmodule
`default_nettype wire
